// File: rtl/sadd_seq_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encodings and default width.
package sadd_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int W_DEFAULT = 4;

endpackage

// File: rtl/sadd_seq_ctrl_fa.sv
// Combinational 1-bit full adder cell used by the serial add datapath.
module sadd_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/sadd_seq_ctrl.sv
// Sequencer feeding two W-bit operands LSB-first through one full-adder cell.
//   state   | meaning
//   ST_IDLE | waiting for start; ready=1
//   ST_RUN  | one operand bit per clock through the adder; busy=1
//   ST_DONE | one-cycle done pulse; sum/cout valid
module sadd_seq_ctrl
    import sadd_seq_ctrl_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         abort,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         s_bit
);

    localparam int            CW   = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  sum_r;
    logic [CW-1:0] count;
    logic          carry;
    logic          cout_r;
    logic          fa_s;
    logic          fa_co;

    sadd_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            count  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else if (abort) begin
            state  <= ST_IDLE;
            sum_r  <= '0;
            cout_r <= 1'b0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        count  <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry <= fa_co;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_r <= {fa_s, sum_r[W-1:1]};
                    count <= count + 1'b1;
                    // final bit: capture carry-out so it is valid alongside done
                    if (count == LAST) begin
                        cout_r <= fa_co;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign sum   = sum_r;
    assign cout  = cout_r;
    assign s_bit = (state == ST_RUN) & fa_s;

endmodule
